// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for dmem_access_ctrl: two requester ports (core, aux) plus the
// single data-memory port. "slave" is the controller view; "master" is the
// view of the surrounding requesters and memory.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // core requester
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ack;
    logic              core_stall;
    logic              core_err;
    // aux (debug/loader) requester
    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic [DATA_W-1:0] aux_rdata;
    logic              aux_ack;
    logic              aux_stall;
    logic              aux_err;
    // memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;
    logic              mem_rdy;
    // status
    logic              busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_ack, core_stall, core_err,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_rdata, aux_ack, aux_stall, aux_err,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata, mem_rdy,
        output busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_ack, core_stall, core_err,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_rdata, aux_ack, aux_stall, aux_err,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata, mem_rdy,
        input  busy
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage. Arbitrates the single
// memory port between the core load/store path and the aux debug/loader
// port with a round-robin grant, and sequences the memRead/memWrite/rdy
// handshake as a two-state FSM (IDLE, WAIT).
// Optional: define DMEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES
// cycles without mem_rdy, completing with err = 1.
module dmem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_ctrl_if.slave  bus
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_AUX  = 1'b1;

    state_t            r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_aux_rdata;
    logic              r_core_ack;
    logic              r_aux_ack;

    logic              w_core_elig;
    logic              w_aux_elig;
    logic              w_any_elig;
    logic              w_pick_aux;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_core_err;
    logic              r_aux_err;
    logic              w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == CNT_LAST);
`endif

    // A requester sitting in its ack cycle is not eligible, so a held req
    // is never serviced twice; ties go to whoever was not granted last.
    assign w_core_elig = bus.core_req & ~r_core_ack;
    assign w_aux_elig  = bus.aux_req  & ~r_aux_ack;
    assign w_any_elig  = w_core_elig | w_aux_elig;
    assign w_pick_aux  = w_aux_elig & (~w_core_elig | (r_last_grant == GNT_CORE));

    assign w_sel_we    = w_pick_aux ? bus.aux_we    : bus.core_we;
    assign w_sel_addr  = w_pick_aux ? bus.aux_addr  : bus.core_addr;
    assign w_sel_wdata = w_pick_aux ? bus.aux_wdata : bus.core_wdata;

    // Grant/access FSM; all memory strobes and requester responses registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= GNT_CORE;
            r_last_grant <= GNT_AUX;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_core_rdata <= '0;
            r_aux_rdata  <= '0;
            r_core_ack   <= 1'b0;
            r_aux_ack    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_core_err   <= 1'b0;
            r_aux_err    <= 1'b0;
`endif
        end else begin
            r_core_ack <= 1'b0;
            r_aux_ack  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            r_core_err <= 1'b0;
            r_aux_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any_elig) begin
                        r_grant      <= w_pick_aux;
                        r_last_grant <= w_pick_aux;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_mem_read   <= ~w_sel_we;
                        r_mem_write  <= w_sel_we;
                        r_state      <= S_WAIT;
`ifdef DMEM_TIMEOUT_EN
                        r_tmo_cnt    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rdy) begin
                        if (r_mem_read) begin
                            if (r_grant == GNT_AUX) r_aux_rdata  <= bus.mem_rdata;
                            else                    r_core_rdata <= bus.mem_rdata;
                        end
                        if (r_grant == GNT_AUX) r_aux_ack  <= 1'b1;
                        else                    r_core_ack <= 1'b1;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= S_IDLE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        // Abort: reads return zero, the requester sees err.
                        if (r_mem_read) begin
                            if (r_grant == GNT_AUX) r_aux_rdata  <= '0;
                            else                    r_core_rdata <= '0;
                        end
                        if (r_grant == GNT_AUX) begin
                            r_aux_ack <= 1'b1;
                            r_aux_err <= 1'b1;
                        end else begin
                            r_core_ack <= 1'b1;
                            r_core_err <= 1'b1;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.core_rdata = r_core_rdata;
    assign bus.aux_rdata  = r_aux_rdata;
    assign bus.core_ack   = r_core_ack;
    assign bus.aux_ack    = r_aux_ack;
    assign bus.core_stall = bus.core_req & ~r_core_ack;
    assign bus.aux_stall  = bus.aux_req  & ~r_aux_ack;
    assign bus.busy       = (r_state == S_WAIT);
`ifdef DMEM_TIMEOUT_EN
    assign bus.core_err   = r_core_err;
    assign bus.aux_err    = r_aux_err;
`else
    assign bus.core_err   = 1'b0;
    assign bus.aux_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a cycle-by-cycle vector table covering
// arbitration, read/write sequencing and held requests, followed by
// hand-written sequences for mid-access reset and (when DMEM_TIMEOUT_EN is
// defined) the WAIT timeout.
module tb_dmem_access_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_TIMEOUT_EN
    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    // One row per clock cycle: inputs driven for that cycle, outputs expected
    // in that same cycle (sampled on the falling edge).
    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        areq, awe;
        logic [31:0] aaddr, awd;
        logic [31:0] mrd;
        logic        mrdy;
        logic        e_rd, e_wr;
        logic [31:0] e_addr, e_wd;
        logic        e_cack, e_aack, e_cst, e_ast;
        logic [31:0] e_crd, e_ard;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    task automatic chk1(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic clr();
        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.aux_req    = 1'b0;
        bus.aux_we     = 1'b0;
        bus.aux_addr   = '0;
        bus.aux_wdata  = '0;
        bus.mem_rdata  = '0;
        bus.mem_rdy    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr();
        rst = 1'b1;
        bus.core_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---- reset state (stall follows req combinationally) ----
        @(negedge clk);
        chk1 ("rst.rd",    bus.mem_read,   1'b0);
        chk1 ("rst.wr",    bus.mem_write,  1'b0);
        chk32("rst.addr",  bus.mem_addr,   32'h0);
        chk1 ("rst.cack",  bus.core_ack,   1'b0);
        chk1 ("rst.aack",  bus.aux_ack,    1'b0);
        chk1 ("rst.busy",  bus.busy,       1'b0);
        chk32("rst.crd",   bus.core_rdata, 32'h0);
        chk1 ("rst.cst",   bus.core_stall, 1'b1);
        chk1 ("rst.cerr",  bus.core_err,   1'b0);
        bus.core_req = 1'b0;
        rst = 1'b0;
        step();

        // ---- simultaneous core/aux requests after reset: core, aux, core ----
        add('{1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,32'h200,32'hA5A5A5A5, 32'h0,1'b0,
              1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0,1'b0});
        add('{1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,32'h200,32'hA5A5A5A5, 32'h11111111,1'b1,
              1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0,1'b1});
        add('{1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,32'h200,32'hA5A5A5A5, 32'h0,1'b0,
              1'b0,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b0,1'b1, 32'h11111111,32'h0,1'b0});
        add('{1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,32'h200,32'hA5A5A5A5, 32'hFFFFFFFF,1'b1,
              1'b0,1'b1,32'h200,32'hA5A5A5A5, 1'b0,1'b0,1'b1,1'b1, 32'h11111111,32'h0,1'b1});
        add('{1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,32'h200,32'hA5A5A5A5, 32'h0,1'b0,
              1'b0,1'b0,32'h200,32'hA5A5A5A5, 1'b0,1'b1,1'b1,1'b0, 32'h11111111,32'h0,1'b0});
        add('{1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,32'h200,32'hA5A5A5A5, 32'h22222222,1'b1,
              1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b1,1'b1, 32'h11111111,32'h0,1'b1});
        add('{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h22222222,32'h0,1'b0});
        // mem_rdy while IDLE must be ignored
        add('{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h77777777,1'b1,
              1'b0,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h22222222,32'h0,1'b0});
        // ---- core read 0x10, rdy on first WAIT cycle; inputs change after grant ----
        add('{1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'h22222222,32'h0,1'b0});
        add('{1'b1,1'b0,32'h99,32'h55, 1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF,1'b1,
              1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'h22222222,32'h0,1'b1});
        add('{1'b1,1'b0,32'h99,32'h55, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h10,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0,1'b0});
        add('{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h10,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0,1'b0});
        // ---- core write 0x20, rdy delayed 3 cycles -> write held 4 cycles ----
        add('{1'b1,1'b1,32'h20,32'h12345678, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h10,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0,1'b0});
        for (int k = 0; k < 3; k++)
            add('{1'b1,1'b1,32'h44,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
                  1'b0,1'b1,32'h20,32'h12345678, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0,1'b1});
        add('{1'b1,1'b1,32'h44,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hBAD0BAD0,1'b1,
              1'b0,1'b1,32'h20,32'h12345678, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0,1'b1});
        add('{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h20,32'h12345678, 1'b1,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0,1'b0});
        // ---- held req through ack: no grant in ack cycle, grant on next edge ----
        add('{1'b1,1'b0,32'h30,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h20,32'h12345678, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0,1'b0});
        add('{1'b1,1'b0,32'h30,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h5A5A5A5A,1'b1,
              1'b1,1'b0,32'h30,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0,1'b1});
        add('{1'b1,1'b0,32'h30,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h30,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h5A5A5A5A,32'h0,1'b0});
        add('{1'b1,1'b0,32'h34,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h30,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'h5A5A5A5A,32'h0,1'b0});
        add('{1'b1,1'b0,32'h34,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h6B6B6B6B,1'b1,
              1'b1,1'b0,32'h34,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'h5A5A5A5A,32'h0,1'b1});
        add('{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h34,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h6B6B6B6B,32'h0,1'b0});
        // ---- aux read alone; core_rdata must not move ----
        add('{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h300,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h34,32'h0, 1'b0,1'b0,1'b0,1'b1, 32'h6B6B6B6B,32'h0,1'b0});
        add('{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h300,32'h0, 32'hCAFEF00D,1'b1,
              1'b1,1'b0,32'h300,32'h0, 1'b0,1'b0,1'b0,1'b1, 32'h6B6B6B6B,32'h0,1'b1});
        add('{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h300,32'h0, 1'b0,1'b1,1'b0,1'b0, 32'h6B6B6B6B,32'hCAFEF00D,1'b0});
        add('{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0,
              1'b0,1'b0,32'h300,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h6B6B6B6B,32'hCAFEF00D,1'b0});

        foreach (tbl[i]) begin
            bus.core_req   = tbl[i].creq;
            bus.core_we    = tbl[i].cwe;
            bus.core_addr  = tbl[i].caddr;
            bus.core_wdata = tbl[i].cwd;
            bus.aux_req    = tbl[i].areq;
            bus.aux_we     = tbl[i].awe;
            bus.aux_addr   = tbl[i].aaddr;
            bus.aux_wdata  = tbl[i].awd;
            bus.mem_rdata  = tbl[i].mrd;
            bus.mem_rdy    = tbl[i].mrdy;
            @(negedge clk);
            chk1 ($sformatf("v%0d.rd",   i), bus.mem_read,   tbl[i].e_rd);
            chk1 ($sformatf("v%0d.wr",   i), bus.mem_write,  tbl[i].e_wr);
            chk32($sformatf("v%0d.addr", i), bus.mem_addr,   tbl[i].e_addr);
            chk32($sformatf("v%0d.wd",   i), bus.mem_wdata,  tbl[i].e_wd);
            chk1 ($sformatf("v%0d.cack", i), bus.core_ack,   tbl[i].e_cack);
            chk1 ($sformatf("v%0d.aack", i), bus.aux_ack,    tbl[i].e_aack);
            chk1 ($sformatf("v%0d.cst",  i), bus.core_stall, tbl[i].e_cst);
            chk1 ($sformatf("v%0d.ast",  i), bus.aux_stall,  tbl[i].e_ast);
            chk32($sformatf("v%0d.crd",  i), bus.core_rdata, tbl[i].e_crd);
            chk32($sformatf("v%0d.ard",  i), bus.aux_rdata,  tbl[i].e_ard);
            chk1 ($sformatf("v%0d.busy", i), bus.busy,       tbl[i].e_busy);
            chk1 ($sformatf("v%0d.cerr", i), bus.core_err,   1'b0);
            chk1 ($sformatf("v%0d.aerr", i), bus.aux_err,    1'b0);
            step();
        end

        // ---- reset two cycles into WAIT; last grant (core) must revert to aux ----
        clr();
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h40;
        step();
        @(negedge clk);
        chk1("mrst.w1.rd", bus.mem_read, 1'b1);
        step();
        @(negedge clk);
        chk1("mrst.w2.rd", bus.mem_read, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.core_addr = 32'h50;
        bus.aux_req   = 1'b1;
        bus.aux_we    = 1'b1;
        bus.aux_addr  = 32'h60;
        @(negedge clk);
        chk1("mrst.rd",   bus.mem_read, 1'b0);
        chk1("mrst.busy", bus.busy,     1'b0);
        chk1("mrst.cack", bus.core_ack, 1'b0);
        chk1("mrst.aack", bus.aux_ack,  1'b0);
        step();
        @(negedge clk);
        chk1 ("mrst.tie.rd",   bus.mem_read,  1'b1);
        chk1 ("mrst.tie.wr",   bus.mem_write, 1'b0);
        chk32("mrst.tie.addr", bus.mem_addr,  32'h50);
        chk1 ("mrst.tie.ast",  bus.aux_stall, 1'b1);
        bus.aux_req   = 1'b0;
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 32'h0F0F0F0F;
        step();
        bus.mem_rdy   = 1'b0;
        bus.core_req  = 1'b0;
        @(negedge clk);
        chk1 ("mrst.cack2", bus.core_ack,   1'b1);
        chk1 ("mrst.aack2", bus.aux_ack,    1'b0);
        chk32("mrst.crd",   bus.core_rdata, 32'h0F0F0F0F);
        step();
        @(negedge clk);
        chk1("mrst.idle", bus.busy, 1'b0);

`ifdef DMEM_TIMEOUT_EN
        // ---- timeout: 8 WAIT cycles with no rdy -> ack, err, rdata = 0 ----
        clr();
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h70;
        step();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk1($sformatf("tmo.w%0d.rd",   k), bus.mem_read, 1'b1);
            chk1($sformatf("tmo.w%0d.cack", k), bus.core_ack, 1'b0);
            step();
        end
        bus.core_req = 1'b0;
        @(negedge clk);
        chk1 ("tmo.cack", bus.core_ack,   1'b1);
        chk1 ("tmo.cerr", bus.core_err,   1'b1);
        chk32("tmo.crd",  bus.core_rdata, 32'h0);
        chk1 ("tmo.rd",   bus.mem_read,   1'b0);
        chk1 ("tmo.busy", bus.busy,       1'b0);
        step();
        @(negedge clk);
        chk1("tmo.after.rd",   bus.mem_read, 1'b0);
        chk1("tmo.after.cerr", bus.core_err, 1'b0);
        // ---- rdy arriving on the 8th WAIT cycle beats the timeout ----
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h74;
        step();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk1($sformatf("tmo2.w%0d.rd", k), bus.mem_read, 1'b1);
            step();
        end
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 32'h13579BDF;
        step();
        bus.mem_rdy  = 1'b0;
        bus.core_req = 1'b0;
        @(negedge clk);
        chk1 ("tmo2.cack", bus.core_ack,   1'b1);
        chk1 ("tmo2.cerr", bus.core_err,   1'b0);
        chk32("tmo2.crd",  bus.core_rdata, 32'h13579BDF);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the data-memory block (addr, data_in, data_out, memRead, memWrite, rdy handshake) in the MEM stage.
- Shares that single memory port between two requesters:
  - core: the pipeline load/store path.
  - aux: the debug/loader port.
- Provides per-requester stall/ack handshakes and a round-robin grant, so the memory never sees two requesters' accesses at once.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort. Used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- core_req  in  1  core access request; held until core_ack.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_rdata  out  DATA_W  read data, valid in the core_ack cycle.
- core_ack  out  1  one-cycle completion pulse.
- core_stall  out  1  core_req & ~core_ack; combinational.
- core_err  out  1  timeout flag, qualified by core_ack.
- aux_req, aux_we, aux_addr, aux_wdata, aux_rdata, aux_ack, aux_stall, aux_err: same as the core_* ports, for aux.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out.
- mem_read  out  1  to memRead.
- mem_write  out  1  to memWrite.
- mem_rdy  in  1  memory ready.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface decisions (already decided): one clock, clk. rst is synchronous and active-high.
- Reset values:
  - All outputs 0 except the combinational stalls.
  - state = IDLE, last_grant = aux, so the core wins the first tie.
  - Timeout counter = 0.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - A requester is eligible if its req = 1 and its ack is not high this cycle. The ack cycle is a dead cycle for that requester, so a held req is never double-serviced.
  - Exactly one eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - On grant, at the clock edge:
    - Register grant and last_grant.
    - Register addr to mem_addr and wdata to mem_wdata.
    - Set mem_read = ~we and mem_write = we.
    - Go to WAIT.
  - No eligible requester: stay in IDLE.
- WAIT:
  - mem_read, mem_write, mem_addr and mem_wdata are held stable.
  - When mem_rdy = 1 is sampled:
    - For a read, capture mem_rdata into the granted requester's rdata. For a write, rdata is unchanged.
    - Pulse the granted ack for exactly one cycle.
    - Clear both strobes and return to IDLE.
- Minimum latency: req seen at edge N, strobes high in cycle N+1, mem_rdy high in cycle N+1, ack high in cycle N+2. A read therefore costs 2 cycles.
- Requester inputs (addr, we, wdata) may change after the grant edge without effect.
- mem_read and mem_write are never both high. At most one ack is high in any cycle.
- The non-granted requester's stall stays high for the whole transaction.
- rdata holds its value until the next read completes for that requester.
- Reset asserted in WAIT (mid-access):
  - Strobes drop on the next edge and no ack is issued.
  - last_grant returns to aux.
  - The memory must tolerate the aborted strobe.
- mem_rdy high while in IDLE is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES - 1 without mem_rdy: drop the strobes, pulse ack with err = 1 and rdata = 0 (reads), and return to IDLE.
  - err = 0 on normal completion.
  - mem_rdy in the same cycle as the timeout wins: normal completion, err = 0.
- Undefined:
  - No counter is built, and WAIT waits indefinitely.
  - core_err and aux_err are tied to 0.

Test Plan:
1. Core read only: core_req, we = 0, addr = 0x10, mem returns 0xDEADBEEF with rdy on the first WAIT cycle. Expect mem_read high for 1 cycle, core_ack 2 cycles after req, core_rdata = 0xDEADBEEF, core_stall high for 2 cycles.
2. Core write: we = 1, wdata = 0x12345678, addr = 0x20, rdy delayed 3 cycles. Expect mem_write held 4 cycles with stable addr/data, then core_ack; core_rdata unchanged.
3. Simultaneous core and aux requests after reset:
   - Expect core served first, then aux, then core again if both keep requesting.
   - Expect acks alternating and never overlapping, with one dead IDLE cycle between transactions.
4. Held req through ack: core keeps req high after its ack with aux idle. Expect no grant in the ack cycle, then a new grant on the following edge.
5. Reset mid-access: assert rst 2 cycles into WAIT. Expect mem_read = 0, no ack, busy = 0 next cycle, and the next tie granted to core.
6. DMEM_TIMEOUT_EN, TIMEOUT_CYCLES = 8, mem_rdy held 0:
   - Expect ack with err = 1 and rdata = 0 after 8 WAIT cycles, and strobes low afterwards.
   - Repeat with rdy on cycle 8: expect err = 0.
